// File: rtl/scaler_seq.sv
// -----------------------------------------------------------------------------
// scaler_seq : frame-level sequencer placed in front of the scaler datapath.
//
// It holds the scaler step configuration in shadow registers and applies it
// only at frame boundaries. Pixel enables are gated so that only whole frames
// reach the scaler, and the sequencer can stop after a programmable number of
// frames. It also measures the geometry of incoming frames and flags lines
// whose length differs from the first line of the frame.
//
// Ports
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   cfg_wr_i/adr/dat    register write: 0=ctrl(b0 enable, b1 clear_err),
//                       1=step_x, 2=step_y, 3=frame_limit (0 = unlimited)
//   cfg_pend_o          shadow step update waiting for a frame boundary
//   di_i/de_i/hs_i/vs_i video in (hs/vs high = blanking)
//   do_o/de_o/hs_o/vs_o video out, one cycle later; de_o gated by RUN
//   scl_step_x_o/_y_o   active scaler steps
//   fr_start_o          one-cycle pulse: scaler resets its line state
//   stat_xcnt_o/_ycnt_o width of first line / line count of last frame
//   stat_vld_o          one-cycle pulse when the statistics update
//   err_o               sticky line-length mismatch
//   busy_o / done_o     state is SYNC or RUN / state is DONE
// -----------------------------------------------------------------------------
module scaler_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int STEP_WIDTH = 16,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr_i,
  input  logic [1:0]            cfg_adr_i,
  input  logic [STEP_WIDTH-1:0] cfg_dat_i,
  output logic                  cfg_pend_o,
  input  logic [DATA_WIDTH-1:0] di_i,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic [STEP_WIDTH-1:0] scl_step_x_o,
  output logic [STEP_WIDTH-1:0] scl_step_y_o,
  output logic                  fr_start_o,
  output logic [CNT_WIDTH-1:0]  stat_xcnt_o,
  output logic [CNT_WIDTH-1:0]  stat_ycnt_o,
  output logic                  stat_vld_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic                  hs_q, vs_q;
  logic                  line_end, fr_end;
  logic                  enable_q;
  logic [STEP_WIDTH-1:0] shx_q, shy_q, stx_q, sty_q, limit_q;
  logic                  pend_q;
  logic                  wr_step, wr_clr_err;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d, frame_inc;
  logic                  fr_start_d, busy_d, done_d;

  logic [CNT_WIDTH-1:0]  xcnt_q, xcnt_d, xcnt_now;
  logic [CNT_WIDTH-1:0]  ycnt_q, ycnt_d;
  logic [CNT_WIDTH-1:0]  width_q, width_d;
  logic                  first_pend_q, first_pend_d;  // 1 = first line of frame not seen yet
  logic [CNT_WIDTH-1:0]  stat_x_d, stat_y_d;
  logic                  stat_vld_d, err_set, err_d;

  logic [DATA_WIDTH-1:0] do_q;
  logic                  de_q, hs_out_q, vs_out_q;
  logic                  fr_start_q, busy_q, done_q;
  logic [CNT_WIDTH-1:0]  stat_x_q, stat_y_q;
  logic                  stat_vld_q, err_q;

  assign line_end   = hs_i & ~hs_q;
  assign fr_end     = vs_i & ~vs_q;
  assign wr_step    = cfg_wr_i & ((cfg_adr_i == 2'd1) | (cfg_adr_i == 2'd2));
  assign wr_clr_err = cfg_wr_i & (cfg_adr_i == 2'd0) & cfg_dat_i[1];

  // ---------------------------------------------------------------------------
  // Blanking edge history and configuration / shadow registers.
  // hs_q/vs_q reset high so that a full low-to-high vs transition is required
  // after reset before a frame end is recognised.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      enable_q <= 1'b0;
      shx_q    <= {STEP_WIDTH{1'b0}};
      shy_q    <= {STEP_WIDTH{1'b0}};
      stx_q    <= {STEP_WIDTH{1'b0}};
      sty_q    <= {STEP_WIDTH{1'b0}};
      limit_q  <= {STEP_WIDTH{1'b0}};
      pend_q   <= 1'b0;
    end else begin
      hs_q <= hs_i;
      vs_q <= vs_i;
      if (cfg_wr_i) begin
        case (cfg_adr_i)
          2'd0:    enable_q <= cfg_dat_i[0];
          2'd1:    shx_q    <= cfg_dat_i;
          2'd2:    shy_q    <= cfg_dat_i;
          2'd3:    limit_q  <= cfg_dat_i;
          default: enable_q <= enable_q;
        endcase
      end
      // The active step takes the shadow value as it stood before this
      // cycle, so a coincident write waits for the next frame end.
      if (fr_end) begin
        stx_q <= shx_q;
        sty_q <= shy_q;
      end
      if (wr_step) begin
        pend_q <= 1'b1;
      end else if (fr_end) begin
        pend_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register and frame counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // FSM next-state logic. RUN only leaves at a frame end, so a frame that
  // has started to pass is never truncated by clearing enable.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    frame_inc   = sat_inc(frame_cnt_q);
    case (state_q)
      ST_IDLE: begin
        if (enable_q) begin
          state_d = ST_SYNC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (!enable_q) begin
          state_d = ST_IDLE;
        end else if (fr_end) begin
          state_d     = ST_RUN;
          frame_cnt_d = CNT_ZERO;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_RUN: begin
        if (fr_end) begin
          frame_cnt_d = frame_inc;
          if ((limit_q != {STEP_WIDTH{1'b0}}) && (32'(frame_inc) == 32'(limit_q))) begin
            state_d = ST_DONE;
          end else if (!enable_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!enable_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs, computed from the transition and registered below.
  always_comb begin
    fr_start_d = 1'b0;
    if (fr_end && (state_d == ST_RUN) &&
        ((state_q == ST_SYNC) || (state_q == ST_RUN))) begin
      fr_start_d = 1'b1;
    end else begin
      fr_start_d = 1'b0;
    end
    busy_d = (state_d == ST_SYNC) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Geometry measurement. A line end and frame end on the same cycle count
  // the line first, so the latched statistics include it.
  // ---------------------------------------------------------------------------
  always_comb begin
    xcnt_now     = de_i ? sat_inc(xcnt_q) : xcnt_q;
    xcnt_d       = xcnt_q;
    ycnt_d       = ycnt_q;
    width_d      = width_q;
    first_pend_d = first_pend_q;
    stat_x_d     = stat_x_q;
    stat_y_d     = stat_y_q;
    stat_vld_d   = 1'b0;
    err_set      = 1'b0;
    if (state_q == ST_IDLE) begin
      xcnt_d       = CNT_ZERO;
      ycnt_d       = CNT_ZERO;
      first_pend_d = 1'b1;
    end else begin
      if (line_end && (xcnt_now != CNT_ZERO)) begin
        if (first_pend_q) begin
          width_d      = xcnt_now;
          first_pend_d = 1'b0;
        end else if (xcnt_now != width_q) begin
          err_set = 1'b1;
        end else begin
          err_set = 1'b0;
        end
        ycnt_d = sat_inc(ycnt_q);
        xcnt_d = CNT_ZERO;
      end else if (line_end) begin
        xcnt_d = CNT_ZERO;
      end else begin
        xcnt_d = xcnt_now;
      end
      if (fr_end) begin
        stat_x_d     = width_d;
        stat_y_d     = ycnt_d;
        stat_vld_d   = 1'b1;
        xcnt_d       = CNT_ZERO;
        ycnt_d       = CNT_ZERO;
        first_pend_d = 1'b1;
      end else begin
        stat_vld_d = 1'b0;
      end
    end
  end

  // Sticky error: a new mismatch wins over a simultaneous clear.
  always_comb begin
    if (err_set) begin
      err_d = 1'b1;
    end else if (wr_clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Geometry counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xcnt_q       <= CNT_ZERO;
      ycnt_q       <= CNT_ZERO;
      width_q      <= CNT_ZERO;
      first_pend_q <= 1'b1;
    end else begin
      xcnt_q       <= xcnt_d;
      ycnt_q       <= ycnt_d;
      width_q      <= width_d;
      first_pend_q <= first_pend_d;
    end
  end

  // Registered outputs: video passthrough, pulses, status and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_q       <= {DATA_WIDTH{1'b0}};
      de_q       <= 1'b0;
      hs_out_q   <= 1'b1;
      vs_out_q   <= 1'b1;
      fr_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stat_x_q   <= CNT_ZERO;
      stat_y_q   <= CNT_ZERO;
      stat_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      do_q       <= di_i;
      de_q       <= de_i & (state_q == ST_RUN);
      hs_out_q   <= hs_i;
      vs_out_q   <= vs_i;
      fr_start_q <= fr_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      stat_x_q   <= stat_x_d;
      stat_y_q   <= stat_y_d;
      stat_vld_q <= stat_vld_d;
      err_q      <= err_d;
    end
  end

  assign do_o         = do_q;
  assign de_o         = de_q;
  assign hs_o         = hs_out_q;
  assign vs_o         = vs_out_q;
  assign scl_step_x_o = stx_q;
  assign scl_step_y_o = sty_q;
  assign cfg_pend_o   = pend_q;
  assign fr_start_o   = fr_start_q;
  assign stat_xcnt_o  = stat_x_q;
  assign stat_ycnt_o  = stat_y_q;
  assign stat_vld_o   = stat_vld_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_scaler_seq.sv
// -----------------------------------------------------------------------------
// tb_scaler_seq : directed testbench for scaler_seq.
// Small frames (8 pixels x 4 lines) keep the run short; CNT_WIDTH is reduced
// to 6 so that counter saturation can be reached with a 70-pixel line.
// -----------------------------------------------------------------------------
module tb_scaler_seq;

  localparam int DW = 8;
  localparam int SW = 16;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_wr_i = 1'b0;
  logic [1:0]    cfg_adr_i = 2'd0;
  logic [SW-1:0] cfg_dat_i = 16'h0000;
  logic          cfg_pend_o;
  logic [DW-1:0] di_i = 8'h00;
  logic          de_i = 1'b0;
  logic          hs_i = 1'b1;
  logic          vs_i = 1'b1;
  logic [DW-1:0] do_o;
  logic          de_o, hs_o, vs_o;
  logic [SW-1:0] scl_step_x_o, scl_step_y_o;
  logic          fr_start_o;
  logic [CW-1:0] stat_xcnt_o, stat_ycnt_o;
  logic          stat_vld_o, err_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  // Running event counters, sampled on the falling edge.
  int n_de  = 0;
  int n_fs  = 0;
  int n_vld = 0;
  int last_sx = 0;
  int last_sy = 0;
  int de0, fs0, vld0;

  scaler_seq #(.DATA_WIDTH(DW), .STEP_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_i(cfg_wr_i), .cfg_adr_i(cfg_adr_i), .cfg_dat_i(cfg_dat_i),
    .cfg_pend_o(cfg_pend_o),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
    .scl_step_x_o(scl_step_x_o), .scl_step_y_o(scl_step_y_o),
    .fr_start_o(fr_start_o),
    .stat_xcnt_o(stat_xcnt_o), .stat_ycnt_o(stat_ycnt_o), .stat_vld_o(stat_vld_o),
    .err_o(err_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_de <= n_de + int'(de_o);
    n_fs <= n_fs + int'(fr_start_o);
    if (stat_vld_o) begin
      n_vld   <= n_vld + 1;
      last_sx <= int'(stat_xcnt_o);
      last_sy <= int'(stat_ycnt_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; a pending config write lasts exactly this cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
    cfg_wr_i = 1'b0;
  endtask

  task automatic cfg_set(input logic [1:0] adr, input logic [SW-1:0] dat);
    cfg_wr_i  = 1'b1;
    cfg_adr_i = adr;
    cfg_dat_i = dat;
  endtask

  task automatic hblank(input int n);
    for (int i = 0; i < n; i++) begin
      hs_i = 1'b1; de_i = 1'b0;
      cyc();
    end
  endtask

  task automatic line(input int w);
    for (int i = 0; i < w; i++) begin
      vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b1; di_i = DW'(i);
      cyc();
    end
    hblank(2);
  endtask

  task automatic vblank(input int n);
    for (int i = 0; i < n; i++) begin
      vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b0;
      cyc();
    end
  endtask

  task automatic frame(input int h, input int w);
    for (int i = 0; i < h; i++) line(w);
    vblank(3);
  endtask

  task automatic snap();
    de0 = n_de; fs0 = n_fs; vld0 = n_vld;
  endtask

  initial begin
    // ---- reset held with toggling video ----
    for (int i = 0; i < 4; i++) begin
      hs_i = i[0]; vs_i = i[0]; de_i = 1'b1; di_i = 8'hFF;
      cfg_set(2'd1, 16'h1234);
      cyc();
    end
    chk("rst_do", 32'(do_o), 32'h0);
    chk("rst_de", 32'(de_o), 32'h0);
    chk("rst_hs", 32'(hs_o), 32'h1);
    chk("rst_vs", 32'(vs_o), 32'h1);
    chk("rst_stepx", 32'(scl_step_x_o), 32'h0);
    chk("rst_pend", 32'(cfg_pend_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);

    // ---- release, passthrough with enable=0 ----
    rst_n = 1'b1;
    hs_i = 1'b0; vs_i = 1'b0; de_i = 1'b1; di_i = 8'h5A;
    cyc();
    chk("pt_do", 32'(do_o), 32'h5A);
    chk("pt_hs", 32'(hs_o), 32'h0);
    chk("pt_vs", 32'(vs_o), 32'h0);
    chk("pt_de_gated", 32'(de_o), 32'h0);
    hs_i = 1'b1; de_i = 1'b0;
    cyc();
    chk("pt_hs_hi", 32'(hs_o), 32'h1);
    vblank(3);

    // ---- whole frame in IDLE: nothing gated through, no stats ----
    snap();
    frame(4, 8);
    chk("idle_de", 32'(n_de - de0), 32'd0);
    chk("idle_fs", 32'(n_fs - fs0), 32'd0);
    chk("idle_vld", 32'(n_vld - vld0), 32'd0);

    // ---- enable mid-frame: SYNC, de gated until the vs rise ----
    snap();
    line(8);
    cfg_set(2'd0, 16'h0001);
    hblank(2);
    chk("sync_busy", 32'(busy_o), 32'h1);
    line(8);
    line(8);
    vblank(3);
    chk("sync_de", 32'(n_de - de0), 32'd0);
    chk("sync_fs", 32'(n_fs - fs0), 32'd1);
    chk("sync_vld", 32'(n_vld - vld0), 32'd1);
    chk("sync_sx", 32'(last_sx), 32'd8);
    chk("sync_sy", 32'(last_sy), 32'd2);

    // ---- first RUN frame ----
    snap();
    frame(4, 8);
    chk("run_de", 32'(n_de - de0), 32'd32);
    chk("run_fs", 32'(n_fs - fs0), 32'd1);
    chk("run_sx", 32'(last_sx), 32'd8);
    chk("run_sy", 32'(last_sy), 32'd4);
    chk("run_err", 32'(err_o), 32'h0);
    chk("run_busy", 32'(busy_o), 32'h1);

    // ---- shadow step_x written mid-frame ----
    line(8);
    cfg_set(2'd1, 16'h0800);
    hblank(1);
    chk("shx_pend", 32'(cfg_pend_o), 32'h1);
    chk("shx_hold", 32'(scl_step_x_o), 32'h0);
    line(8); line(8); line(8);
    chk("shx_hold2", 32'(scl_step_x_o), 32'h0);
    vblank(1);
    chk("shx_apply", 32'(scl_step_x_o), 32'h0800);
    chk("shx_pend_clr", 32'(cfg_pend_o), 32'h0);
    vblank(2);

    // ---- step_y written on the fr_end cycle applies one frame later ----
    line(8); line(8); line(8); line(8);
    cfg_set(2'd2, 16'h0123);
    vblank(1);
    chk("shy_coinc_hold", 32'(scl_step_y_o), 32'h0);
    chk("shy_coinc_pend", 32'(cfg_pend_o), 32'h1);
    vblank(2);
    frame(4, 8);
    chk("shy_apply", 32'(scl_step_y_o), 32'h0123);
    chk("shy_pend_clr", 32'(cfg_pend_o), 32'h0);
    chk("shx_kept", 32'(scl_step_x_o), 32'h0800);

    // ---- short line sets sticky err ----
    line(8); line(8); line(7); line(8);
    vblank(3);
    chk("err_set", 32'(err_o), 32'h1);
    chk("err_sx", 32'(last_sx), 32'd8);
    chk("err_sy", 32'(last_sy), 32'd4);
    frame(4, 8);
    chk("err_sticky", 32'(err_o), 32'h1);
    cfg_set(2'd0, 16'h0003);
    hblank(1);
    chk("err_clr", 32'(err_o), 32'h0);

    // ---- width counter saturates at 2^CW-1 ----
    snap();
    frame(1, 70);
    chk("sat_sx", 32'(last_sx), 32'd63);
    chk("sat_sy", 32'(last_sy), 32'd1);
    chk("sat_de", 32'(n_de - de0), 32'd70);

    // ---- disable during line 2: frame finishes, then IDLE ----
    snap();
    line(8);
    cfg_set(2'd0, 16'h0000);
    hblank(1);
    line(8); line(8); line(8);
    vblank(3);
    chk("dis_de", 32'(n_de - de0), 32'd32);
    chk("dis_fs", 32'(n_fs - fs0), 32'd0);
    chk("dis_busy", 32'(busy_o), 32'h0);

    // ---- frame limit = 4 ----
    cfg_set(2'd3, 16'd4);
    hblank(1);
    cfg_set(2'd0, 16'h0001);
    hblank(2);
    snap();
    frame(4, 8);
    chk("lim_sync_de", 32'(n_de - de0), 32'd0);
    de0 = n_de;
    for (int f = 0; f < 4; f++) frame(4, 8);
    chk("lim_de", 32'(n_de - de0), 32'd128);
    chk("lim_fs", 32'(n_fs - fs0), 32'd4);
    chk("lim_done", 32'(done_o), 32'h1);
    chk("lim_busy", 32'(busy_o), 32'h0);
    snap();
    frame(4, 8);
    chk("done_de", 32'(n_de - de0), 32'd0);
    cfg_set(2'd3, 16'd0);
    hblank(1);
    chk("done_norestart", 32'(done_o), 32'h1);
    cfg_set(2'd0, 16'h0000);
    hblank(2);
    chk("done_idle", 32'(done_o), 32'h0);
    chk("done_idle_busy", 32'(busy_o), 32'h0);

    // ---- async reset during vertical blanking ----
    cfg_set(2'd0, 16'h0001);
    hblank(2);
    frame(4, 8);
    line(8); line(8); line(8); line(8);
    vblank(1);
    rst_n = 1'b0;
    #1;
    chk("arst_fs", 32'(fr_start_o), 32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    chk("arst_stepx", 32'(scl_step_x_o), 32'h0);
    chk("arst_vs", 32'(vs_o), 32'h1);
    vblank(2);
    rst_n = 1'b1;
    snap();
    cfg_set(2'd0, 16'h0001);
    vblank(3);
    chk("arst_nofs", 32'(n_fs - fs0), 32'd0);
    frame(4, 8);
    chk("arst_sync_de", 32'(n_de - de0), 32'd0);
    chk("arst_sync_fs", 32'(n_fs - fs0), 32'd1);
    snap();
    frame(4, 8);
    chk("arst_run_de", 32'(n_de - de0), 32'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scaler_seq.md
Name: scaler_seq

Overview:
- Frame-level sequencer that sits between the video source and the scaler datapath.
- Holds the scaler step configuration in shadow registers and applies it only at frame boundaries.
- Gates pixel enables so that only whole frames reach the scaler, and stops after a programmable frame count.
- Measures incoming frame geometry (width/height) and flags inconsistent line lengths.

Parameters:
DATA_WIDTH, 8, pixel data width of di_i/do_o
STEP_WIDTH, 16, width of scaler step registers and cfg_dat_i
CNT_WIDTH, 12, width of pixel/line/frame counters (saturating)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
cfg_wr_i  in  1  register write strobe, one write per cycle, always accepted
cfg_adr_i  in  2  0=ctrl(bit0 enable, bit1 clear_err), 1=step_x, 2=step_y, 3=frame_limit (0=unlimited)
cfg_dat_i  in  STEP_WIDTH  write data
cfg_pend_o  out  1  shadow step update waiting for frame boundary
di_i  in  DATA_WIDTH  pixel data
de_i  in  1  pixel valid
hs_i  in  1  horizontal blanking, high=blank
vs_i  in  1  vertical blanking, high=blank
do_o  out  DATA_WIDTH  registered di_i
de_o  out  1  registered de_i, gated by RUN
hs_o  out  1  registered hs_i
vs_o  out  1  registered vs_i
scl_step_x_o  out  STEP_WIDTH  active horizontal step to scaler
scl_step_y_o  out  STEP_WIDTH  active vertical step to scaler
fr_start_o  out  1  1-cycle pulse, scaler must reset line state
stat_xcnt_o  out  CNT_WIDTH  width of first line of last frame
stat_ycnt_o  out  CNT_WIDTH  lines in last frame
stat_vld_o  out  1  1-cycle pulse when stats update
err_o  out  1  sticky line-length mismatch
busy_o  out  1  state is SYNC or RUN
done_o  out  1  state is DONE

Behaviour:
- Reset values: do_o=0, de_o=0, hs_o=1, vs_o=1, steps=0, shadows=0, frame_limit=0, enable=0, all pulses/flags=0, state=IDLE.
- Edge detect: hs_r/vs_r hold the previous cycle's hs_i/vs_i.
  - line_end = hs_i & !hs_r
  - fr_end = vs_i & !vs_r
- Video passthrough: do/hs/vs have a fixed 1-cycle latency. de_o = de_i delayed 1 cycle AND (state==RUN on the sampling cycle).
- Config writes:
  - Addr 1/2 write the shadow and set cfg_pend_o.
  - On any fr_end: active step <= shadow (visible the next cycle) and cfg_pend_o clears.
  - A write on the same cycle as fr_end lands in the shadow, keeps cfg_pend_o set, and applies at the following fr_end.
  - Addr 0 bit1 clears err_o. Addr 3 takes effect immediately.
- FSM:
  - IDLE: wait for enable=1, then go to SYNC.
  - SYNC: if enable=0, go to IDLE. On fr_end, go to RUN, pulse fr_start_o, frame_cnt=0.
  - RUN:
    - On fr_end, frame_cnt++ (saturating).
    - If frame_limit!=0 and the new frame_cnt==frame_limit, go to DONE.
    - Else if enable=0, go to IDLE.
    - Else stay in RUN and pulse fr_start_o.
    - Enable cleared mid-frame finishes the current frame (no truncated frames).
  - DONE: de_o held 0. Go to IDLE when enable=0. Writing a new frame_limit does not restart; enable must toggle.
- Geometry measurement, active in SYNC/RUN/DONE:
  - xcnt counts de_i cycles.
  - On line_end with xcnt!=0: if this is the first line, store width; else if xcnt!=width, set err_o. Then ycnt++ and xcnt=0.
  - A line_end with xcnt==0 is ignored.
  - On fr_end: stat_xcnt_o=width, stat_ycnt_o=ycnt, stat_vld_o pulses 1 cycle; xcnt, ycnt and the first-line flag clear.
  - If line_end and fr_end coincide, the line is counted first, then stats latch.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Async reset mid-frame returns everything to reset values immediately. After release, the FSM needs a full vs_i low-to-high transition before RUN.

Test Plan:
- Reset/passthrough: hold rst_n=0 with toggling video -> outputs at reset values. Release, enable=0 -> hs_o/vs_o track inputs 1 cycle late, de_o=0.
- Sync entry: enable=1 mid-frame (active lines) -> de_o stays 0 until the first vs_i rise, then fr_start_o pulses once. The next frame's de_o matches de_i delayed 1 cycle.
- Shadow apply: write step_x=0x0800 mid-frame -> scl_step_x_o unchanged and cfg_pend_o=1 until fr_end, then 0x0800 one cycle later and cfg_pend_o=0. A write coincident with fr_end applies one frame later.
- Geometry: 640x480 frames -> stat_vld_o pulses per frame with 640/480, err_o=0. One line of 639 -> err_o=1 until ctrl bit1 write.
- Frame limit: frame_limit=4, enable=1 -> exactly 4 gated frames, then done_o=1 and de_o=0. Enable=0 -> IDLE, busy_o=0.
- Disable mid-frame: clear enable during line 100 of RUN -> the rest of the frame still passes, IDLE at fr_end, no fr_start_o.
